// File: rtl/prog_timer_array.sv
// prog_timer_array: CHANNELS programmable downcounters sharing one
// 32 kHz prescaler, with cascading, one-shot mode and read-clear flags.
module prog_timer_array #(
  parameter int CHANNELS    = 2,
  parameter int COUNT_WIDTH = 8,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick_32k,
  input  logic [CHANNELS-1:0]    ext_event,
  input  logic                   wr_en,
  input  logic [CH_W-1:0]        wr_ch,
  input  logic [2:0]             wr_field,
  input  logic [COUNT_WIDTH-1:0] wr_data,
  input  logic [CH_W-1:0]        rd_ch,
  input  logic [2:0]             rd_field,
  input  logic                   rd_strobe,
  output logic [COUNT_WIDTH-1:0] rd_data,
  output logic [CHANNELS-1:0]    factor,
  output logic [CHANNELS-1:0]    underflow,
  output logic                   irq
);

  localparam logic [2:0] F_CTRL = 3'd0;
  localparam logic [2:0] F_RLD  = 3'd1;
  localparam logic [2:0] F_SEL  = 3'd2;
  localparam logic [2:0] F_MSK  = 3'd3;
  localparam logic [2:0] F_CNT  = 3'd4;
  localparam logic [2:0] F_FACT = 3'd5;

  typedef logic [COUNT_WIDTH-1:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);

  logic [6:0]          pre_q, pre_d;
  cnt_t                cnt_q [CHANNELS];
  cnt_t                cnt_d [CHANNELS];
  cnt_t                rld_q [CHANNELS];
  cnt_t                rld_d [CHANNELS];
  logic [2:0]          sel_q [CHANNELS];
  logic [2:0]          sel_d [CHANNELS];
  logic [CHANNELS-1:0] run_q, run_d;
  logic [CHANNELS-1:0] one_q, one_d;
  logic [CHANNELS-1:0] cas_q, cas_d;
  logic [CHANNELS-1:0] msk_q, msk_d;
  logic [CHANNELS-1:0] fac_q, fac_d;
  logic [CHANNELS-1:0] ch_tick;
  logic [CHANNELS-1:0] rst_pls;
  logic [7:0]          tap;

  // Prescaler taps: select s fires when the low 9-s bits are all ones.
  always_comb begin
    tap = '0;
    for (int s = 2; s < 8; s++) begin
      tap[s] = tick_32k && (&(pre_q | ~(7'h7f >> (s - 2))));
    end
    pre_d = pre_q + {6'd0, tick_32k};
  end

  // Per-channel tick, underflow chain and next-state for all registers.
  always_comb begin
    logic carry;
    logic wsel;
    logic wctl;
    carry     = 1'b0;
    wsel      = 1'b0;
    wctl      = 1'b0;
    ch_tick   = '0;
    rst_pls   = '0;
    underflow = '0;
    cnt_d     = cnt_q;
    rld_d     = rld_q;
    sel_d     = sel_q;
    run_d     = run_q;
    one_d     = one_q;
    cas_d     = cas_q;
    msk_d     = msk_q;
    fac_d     = fac_q;
    for (int c = 0; c < CHANNELS; c++) begin
      wsel       = wr_en && (int'(wr_ch) == c);
      wctl       = wsel && (wr_field == F_CTRL);
      rst_pls[c] = wctl && wr_data[1];

      if ((c > 0) && cas_q[c]) begin
        ch_tick[c] = carry;
      end else if (sel_q[c] == 3'd0) begin
        ch_tick[c] = ext_event[c];
      end else begin
        ch_tick[c] = tap[sel_q[c]];
      end

      underflow[c] = run_q[c] && ch_tick[c]
                     && !rst_pls[c] && (cnt_q[c] == ONE);
      carry = underflow[c];

      if (wsel) begin
        unique case (1'b1)
          wr_field == F_CTRL: begin
            run_d[c] = wr_data[0];
            one_d[c] = wr_data[2];
            cas_d[c] = (c > 0) && wr_data[3];
          end
          wr_field == F_RLD: rld_d[c] = wr_data;
          wr_field == F_SEL: sel_d[c] = wr_data[2:0];
          wr_field == F_MSK: msk_d[c] = wr_data[0];
          default: ;
        endcase
      end

      if (underflow[c] && one_q[c] && !wctl) begin
        run_d[c] = 1'b0;
      end

      if (rst_pls[c]) begin
        cnt_d[c] = rld_q[c];
      end else if (run_q[c] && ch_tick[c]) begin
        if (cnt_q[c] == ONE) begin
          cnt_d[c] = rld_d[c];
        end else begin
          cnt_d[c] = cnt_q[c] - ONE;
        end
      end

      if (underflow[c]) begin
        fac_d[c] = 1'b1;
      end else if (rd_strobe && (rd_field == F_FACT)
                   && (int'(rd_ch) == c)) begin
        fac_d[c] = 1'b0;
      end
    end
  end

  // State registers; reset aborts everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      run_q <= '0;
      one_q <= '0;
      cas_q <= '0;
      msk_q <= '0;
      fac_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
        rld_q[c] <= '0;
        sel_q[c] <= '0;
      end
    end else begin
      pre_q <= pre_d;
      run_q <= run_d;
      one_q <= one_d;
      cas_q <= cas_d;
      msk_q <= msk_d;
      fac_q <= fac_d;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= cnt_d[c];
        rld_q[c] <= rld_d[c];
        sel_q[c] <= sel_d[c];
      end
    end
  end

  // Combinational readback, zero-extended; unknown channel reads 0.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(rd_ch) == c) begin
        unique case (1'b1)
          rd_field == F_CTRL: begin
            rd_data[0] = run_q[c];
            rd_data[2] = one_q[c];
            rd_data[3] = cas_q[c];
          end
          rd_field == F_RLD:  rd_data      = rld_q[c];
          rd_field == F_SEL:  rd_data[2:0] = sel_q[c];
          rd_field == F_MSK:  rd_data[0]   = msk_q[c];
          rd_field == F_CNT:  rd_data      = cnt_q[c];
          rd_field == F_FACT: rd_data[0]   = fac_q[c];
          default:            rd_data      = '0;
        endcase
      end
    end
  end

  assign factor = fac_q;
  assign irq    = |(fac_q & msk_q);

endmodule
